// File: rtl/mor1kx_rf_banked_pkg.sv
// rtl/mor1kx_rf_banked_pkg.sv - shared types and constants for the banked GPR file
package mor1kx_rf_banked_pkg;

    // Clear sequencer: INIT zeroes every entry of every set, RUN is normal operation.
    typedef enum logic [0:0] {
        SEQ_INIT = 1'b0,
        SEQ_RUN  = 1'b1
    } rf_seq_state_t;

    // SPR group number of the GPR window (spr address bits [15:9]).
    localparam logic [6:0] SPR_GRP_GPR = 7'h2;

    // Width of the set selector; a single set still gets a 1-bit selector.
    function automatic int rf_set_width(input int num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

endpackage

// File: rtl/mor1kx_simple_dpram_sclk.sv
// rtl/mor1kx_simple_dpram_sclk.sv - single-clock simple dual-port RAM with registered read
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-low reset, clears the read data register only
//   raddr - read address, sampled when re is high
//   re    - read enable; dout holds its value while re is low
//   waddr - write address
//   we    - write enable
//   din   - write data
//   dout  - registered read data
module mor1kx_simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 32,
    parameter int ENABLE_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    // Without bypass a same-cycle write to the read address returns the old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
        end else if (re) begin
            if ((ENABLE_BYPASS != 0) && we && (waddr == raddr)) begin
                dout <= din;
            end else begin
                dout <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/mor1kx_rf_banked.sv
// rtl/mor1kx_rf_banked.sv - banked (shadow set) GPR file with forwarding and SPR access
//
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   set_i                    - active register set for pipeline reads and writes
//   rd_en_i/rd_adr_i         - per-port read strobe and index (P ports)
//   rd_dat_o                 - per-port operand, one cycle after rd_en_i, forwarding applied
//   bp_valid_i/adr_i/dat_i   - per-stage forwarding sources, stage 0 youngest
//   wr_en_i/wr_adr_i/wr_dat_i - writeback-stage write into the active set
//   spr_bus_*                - SPR bus; group 2 maps {set, index} of every set
//   spr_gpr_ack_o/dat_o      - SPR GPR access acknowledge and read data
//   init_busy_o              - high while the clear sequencer zeroes the RAM
module mor1kx_rf_banked
    import mor1kx_rf_banked_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH    = 32,
    parameter int OPTION_RF_ADDR_WIDTH    = 5,
    parameter int OPTION_RF_NUM_SETS      = 4,
    parameter int OPTION_RF_READ_PORTS    = 2,
    parameter int OPTION_RF_BYPASS_STAGES = 3
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [rf_set_width(OPTION_RF_NUM_SETS)-1:0]             set_i,
    input  logic [OPTION_RF_READ_PORTS-1:0]                         rd_en_i,
    input  logic [OPTION_RF_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0]    rd_adr_i,
    output logic [OPTION_RF_READ_PORTS*OPTION_OPERAND_WIDTH-1:0]    rd_dat_o,
    input  logic [OPTION_RF_BYPASS_STAGES-1:0]                      bp_valid_i,
    input  logic [OPTION_RF_BYPASS_STAGES*OPTION_RF_ADDR_WIDTH-1:0] bp_adr_i,
    input  logic [OPTION_RF_BYPASS_STAGES*OPTION_OPERAND_WIDTH-1:0] bp_dat_i,
    input  logic                                                    wr_en_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]                         wr_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]                         wr_dat_i,
    input  logic [15:0]                                             spr_bus_addr_i,
    input  logic                                                    spr_bus_stb_i,
    input  logic                                                    spr_bus_we_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]                         spr_bus_dat_i,
    output logic                                                    spr_gpr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]                         spr_gpr_dat_o,
    output logic                                                    init_busy_o
);

    localparam int W           = OPTION_OPERAND_WIDTH;
    localparam int AW          = OPTION_RF_ADDR_WIDTH;
    localparam int P           = OPTION_RF_READ_PORTS;
    localparam int S           = OPTION_RF_BYPASS_STAGES;
    localparam int SW          = rf_set_width(OPTION_RF_NUM_SETS);
    localparam int RAW         = SW + AW;
    localparam int NUM_ENTRIES = OPTION_RF_NUM_SETS << AW;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    rf_seq_state_t  state_q, state_d;
    logic [RAW-1:0] cnt_q, cnt_d;
    logic           run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SEQ_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SEQ_INIT: begin
                cnt_d = cnt_q + RAW'(1);
                if (cnt_q == RAW'(NUM_ENTRIES - 1)) begin
                    state_d = SEQ_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SEQ_RUN;
            end
        endcase
    end

    assign run         = (state_q == SEQ_RUN);
    assign init_busy_o = ~run;

    // ------------------------------------------------------------------
    // Shared RAM write port: clear > pipeline writeback > SPR write
    // ------------------------------------------------------------------
    logic           spr_gpr_sel;
    logic           spr_rd_sel;
    logic           spr_wr_ack;
    logic           wr_en_run;
    logic           ram_we;
    logic [RAW-1:0] ram_waddr;
    logic [W-1:0]   ram_wdat;
    logic           spr_addr_unused;

    assign spr_gpr_sel     = spr_bus_stb_i & (spr_bus_addr_i[15:9] == SPR_GRP_GPR);
    assign spr_rd_sel      = spr_gpr_sel & ~spr_bus_we_i;
    // An SPR write waits for a cycle in which the pipeline is not writing back.
    assign spr_wr_ack      = run & spr_gpr_sel & spr_bus_we_i & ~wr_en_i;
    assign wr_en_run       = run & wr_en_i;
    assign spr_addr_unused = ^spr_bus_addr_i;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdat  = '0;
        if (!run) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
        end else if (wr_en_i) begin
            ram_we    = 1'b1;
            ram_waddr = {set_i, wr_adr_i};
            ram_wdat  = wr_dat_i;
        end else if (spr_wr_ack) begin
            ram_we    = 1'b1;
            ram_waddr = spr_bus_addr_i[RAW-1:0];
            ram_wdat  = spr_bus_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline read ports
    // ------------------------------------------------------------------
    logic [W-1:0] port_dat [P];

    for (genvar p = 0; p < P; p++) begin : g_port
        logic [AW-1:0] rd_adr_in;
        logic [AW-1:0] rd_adr_q;
        logic          held_vld_q;
        logic [W-1:0]  held_dat_q;
        logic [W-1:0]  ram_dout;

        assign rd_adr_in = rd_adr_i[p*AW +: AW];

        mor1kx_simple_dpram_sclk #(
            .ADDR_WIDTH    (RAW),
            .DATA_WIDTH    (W),
            .ENABLE_BYPASS (0)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .raddr ({set_i, rd_adr_in}),
            .re    (run & rd_en_i[p]),
            .waddr (ram_waddr),
            .we    (ram_we),
            .din   (ram_wdat),
            .dout  (ram_dout)
        );

        // The RAM snapshot is taken at read time; the held value tracks any
        // pipeline writeback to the same index that lands afterwards (or in the
        // read cycle itself), so the operand stays current while it waits.
        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_adr_q   <= '0;
                held_vld_q <= 1'b0;
                held_dat_q <= '0;
            end else if (rd_en_i[p]) begin
                rd_adr_q   <= rd_adr_in;
                held_vld_q <= wr_en_run & (wr_adr_i == rd_adr_in);
                if (wr_en_run && (wr_adr_i == rd_adr_in)) begin
                    held_dat_q <= wr_dat_i;
                end
            end else if (wr_en_run && (wr_adr_i == rd_adr_q)) begin
                held_vld_q <= 1'b1;
                held_dat_q <= wr_dat_i;
            end
        end

        // Scan oldest to youngest so the youngest matching stage wins.
        always_comb begin
            port_dat[p] = held_vld_q ? held_dat_q : ram_dout;
            for (int s = S - 1; s >= 0; s--) begin
                if (bp_valid_i[s] && (bp_adr_i[s*AW +: AW] == rd_adr_q)) begin
                    port_dat[p] = bp_dat_i[s*W +: W];
                end
            end
            if (!run) begin
                port_dat[p] = '0;
            end
        end

        assign rd_dat_o[p*W +: W] = port_dat[p];
    end

    // ------------------------------------------------------------------
    // SPR read port
    // ------------------------------------------------------------------
    logic         spr_rd_ack_q;
    logic         spr_rd_ack;
    logic [W-1:0] spr_ram_dout;

    mor1kx_simple_dpram_sclk #(
        .ADDR_WIDTH    (RAW),
        .DATA_WIDTH    (W),
        .ENABLE_BYPASS (0)
    ) u_spr_ram (
        .clk   (clk),
        .rst   (rst),
        .raddr (spr_bus_addr_i[RAW-1:0]),
        .re    (run & spr_rd_sel),
        .waddr (ram_waddr),
        .we    (ram_we),
        .din   (ram_wdat),
        .dout  (spr_ram_dout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            spr_rd_ack_q <= 1'b0;
        end else begin
            spr_rd_ack_q <= run & spr_rd_sel;
        end
    end

    // Qualified by the live strobe so the ack drops as soon as the master lets go.
    assign spr_rd_ack    = spr_rd_ack_q & spr_rd_sel;
    assign spr_gpr_ack_o = spr_wr_ack | spr_rd_ack;
    assign spr_gpr_dat_o = spr_rd_ack ? spr_ram_dout : '0;

endmodule

// File: doc/mor1kx_rf_banked.md
MOR1KX_RF_BANKED -- requirements
Module: mor1kx_rf_banked

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: data word width.
REQ-002 SHALL have parameter OPTION_RF_ADDR_WIDTH, default 5: GPR index width (32 regs per set).
REQ-003 SHALL have parameter OPTION_RF_NUM_SETS, default 4: shadow register sets, power of two, 1..16.
REQ-004 SHALL have parameter OPTION_RF_READ_PORTS, default 2: independent read ports, 1..4.
REQ-005 SHALL have parameter OPTION_RF_BYPASS_STAGES, default 3: forwarding sources, 1..4; index 0 = youngest stage.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-008 SHALL have port set_i  input  SW = max(1, clog2(NUM_SETS))  active register set for reads and writes.
REQ-009 SHALL have port rd_en_i  input  P  per-port read strobe (fetch-stage address valid).
REQ-010 SHALL have port rd_adr_i  input  P*AW  per-port read index.
REQ-011 SHALL have port rd_dat_o  output  P*W  per-port operand, bypass applied.
REQ-012 SHALL have port bp_valid_i  input  S  per-stage "writes back a GPR".
REQ-013 SHALL have port bp_adr_i  input  S*AW  per-stage destination index.
REQ-014 SHALL have port bp_dat_i  input  S*W  per-stage result.
REQ-015 SHALL have port wr_en_i / wr_adr_i / wr_dat_i  input  1 / AW / W  writeback-stage RAM write.
REQ-016 SHALL have port spr_bus_addr_i / stb_i / we_i / dat_i  input  16 / 1 / 1 / W  SPR bus.
REQ-017 SHALL have port spr_gpr_ack_o / spr_gpr_dat_o  output  1 / W  SPR GPR access acknowledge and read data.
REQ-018 SHALL have port init_busy_o  output  1  high while clear sequencer runs.

Function
REQ-019 Read latency SHALL be 1 cycle: rd_adr_i latched on rd_en_i; RAM data valid on rd_dat_o next cycle.
REQ-020 rd_dat_o[p] SHALL be chosen by priority: lowest-index stage s with bp_valid_i[s] and bp_adr_i[s]==latched adr; else held-write value; else RAM.
REQ-021 A wr_en_i to the address being read in the rd_en_i cycle SHALL be captured into the held-write value (RAM has no internal bypass).
REQ-022 While rd_en_i[p] is low, every wr_en_i to port p's latched address SHALL update its held-write value; held value SHALL clear on next rd_en_i[p] unless that cycle's write matches again.
REQ-023 RAM address SHALL be {set_i, index}; bypass comparisons SHALL use index only; set_i changes SHALL be made only with pipeline empty (caller obligation).
REQ-024 Sequencer states SHALL be INIT and RUN; reset enters INIT with counter 0.
REQ-025 In INIT, one entry per cycle SHALL be written with zero, counter 0..NUM_SETS*32-1, then RUN; INIT lasts NUM_SETS*2^AW cycles (128 default).
REQ-026 In INIT: init_busy_o=1, rd_dat_o=0, wr_en_i ignored, SPR accesses unacknowledged.
REQ-027 SPR GPR window SHALL be spr_bus_addr_i[15:9]==7'h2; set = addr[AW+SW-1:AW], index = addr[AW-1:0].
REQ-028 SPR write SHALL ack same cycle when wr_en_i low; pipeline write has priority; SPR write stalls (no ack) while wr_en_i high.
REQ-029 SPR read SHALL use a dedicated read port; ack asserted the cycle after stb, with valid data; ack deasserts when stb drops.
REQ-030 SPR write SHALL not update bypass/held-write values.

Reset
REQ-031 On rst=0: latched read addresses 0, held-write flags 0, rd_dat_o 0, spr_gpr_ack_o 0, spr_gpr_dat_o 0, init_busy_o 1, state INIT, counter 0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from counter 0 next cycle.

Structure
REQ-033 Shared package SHALL hold sequencer state encoding, SPR group constant 7'h2, and set-width function.
REQ-034 RAM SHALL be one sub-module, mor1kx_simple_dpram_sclk, instantiated P+1 times (P read ports + SPR port), shared write port, bypass disabled.

Verification
REQ-035 Reset then idle -> init_busy_o high exactly 128 cycles; any read afterwards returns 0.
REQ-036 wr r3=0xA5A5_0001, rd r3 next cycle, bp_valid_i[0]=1 adr 3 dat 0x1111 at output cycle -> rd_dat_o=0x1111.
REQ-037 rd_en r5 same cycle as wr r5=0xDEAD_BEEF -> rd_dat_o=0xDEADBEEF one cycle later.
REQ-038 rd_en r7 then low; wr r7=0x42 two cycles later, no bypass -> rd_dat_o=0x42 next cycle, holds.
REQ-039 SPR write addr 0x0465 dat 0x77 (set 3, r5) with wr_en_i high 2 cycles -> ack on 3rd cycle; set_i=3 read r5 -> 0x77; set_i=0 r5 unchanged.
REQ-040 SPR read 0x0465 -> ack and data 0x77 one cycle after stb; rst=0 mid-read -> ack 0, INIT restarts.
